// File: rtl/sram_arb_pkg.sv
// Shared types and sizing constants for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} arb_state_t;

    localparam int MAX_NREQ = 8;
    localparam int ID_W     = $clog2(MAX_NREQ);
    localparam int STALL_W  = 16;

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// Round-robin picker: first set request strictly after ptr_i (modulo NREQ) wins.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // k walks the rotation order; only one i matches each k
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_o && (i == (int'(ptr_i) + k) % NREQ) && req_i[i]) begin
                    any_o    = 1'b1;
                    idx_o    = ID_W'(i);
                    gnt_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: round-robin grant, registered issue, tagged read return, halt/drain.
// Optional SRAM_ARB_PERF_EN adds per-requester saturating stall counters (stall_cnt).
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    input  logic                     halt,
    output logic                     halt_ack,
    input  logic                     sram_busy,
    output logic                     sram_en,
    output logic                     sram_we,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [NREQ*STALL_W-1:0]  stall_cnt
`endif
);

    arb_state_t        state_q;
    logic              halt_ack_q;
    logic [ID_W-1:0]   ptr_q;
    logic              sram_en_q;
    logic              sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [ID_W-1:0]   issue_id_q;
    logic              tag_vld_q [RD_LAT];
    logic [ID_W-1:0]   tag_id_q  [RD_LAT];

    logic              grant_ok;
    logic [NREQ-1:0]   arb_req;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_inflight;

    assign grant_ok = (state_q == RUN) && !halt && !sram_busy;
    assign arb_req  = req & {NREQ{grant_ok}};

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The last tag stage is returning this cycle, so it no longer counts as in flight.
    always_comb begin
        rd_inflight = sram_en_q && !sram_we_q;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            rd_inflight = rd_inflight || tag_vld_q[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q        <= ID_W'(NREQ - 1);
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            issue_id_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            sram_en_q <= gnt_any;
            sram_we_q <= gnt_any && sel_we;
            if (gnt_any) begin
                ptr_q        <= gnt_idx;
                sram_addr_q  <= sel_addr;
                sram_wdata_q <= sel_wdata;
                issue_id_q   <= gnt_idx;
            end
            tag_vld_q[0] <= sram_en_q && !sram_we_q;
            tag_id_q[0]  <= issue_id_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= RUN;
            halt_ack_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt && rd_inflight) begin
                        state_q    <= DRAIN;
                        halt_ack_q <= 1'b0;
                    end else if (halt) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!halt) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end else if (!rd_inflight) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = tag_vld_q[RD_LAT-1] && (tag_id_q[RD_LAT-1] == ID_W'(i));
        end
    end

    assign rdata      = tag_vld_q[RD_LAT-1] ? sram_rdata : '0;
    assign halt_ack   = halt_ack_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

`ifdef SRAM_ARB_PERF_EN
    logic [STALL_W-1:0] stall_q [NREQ];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !gnt[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stall_cnt[i*STALL_W +: STALL_W] = stall_q[i];
        end
    end
`endif

endmodule
